// File: rtl/request_resolver.sv
// request_resolver: latches call buttons and picks the next target floor with a LOOK sweep.
// Define HOME_RETURN_EN to send the car back to floor 0 after IDLE_TIMEOUT idle cycles.
module request_resolver #(
    parameter int NUM_FLOORS   = 8,
    parameter int FLOOR_BITS   = 3,
    parameter int IDLE_TIMEOUT = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call,
    input  logic [FLOOR_BITS-1:0] floor,
    input  logic                  up,
    input  logic                  down,
    input  logic                  open,
    output logic [FLOOR_BITS-1:0] req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy,
    output logic                  sweep_up
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_UP   = 2'd1,
        SERVE_DOWN = 2'd2
    } state_t;

    state_t                state;
    logic                  open_d;
    logic                  closed;
    logic [NUM_FLOORS-1:0] own_mask;
    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic [NUM_FLOORS-1:0] pending_next;
    logic                  has_above;
    logic                  has_below;
    logic [FLOOR_BITS-1:0] lo_above;
    logic [FLOOR_BITS-1:0] hi_below;
    logic [FLOOR_BITS-1:0] dist_up;
    logic [FLOOR_BITS-1:0] dist_dn;
    logic                  home_fire;

    // Own-floor calls are dropped while stopped: the car is already there.
    always_comb begin
        closed   = !up && !down && !open;
        own_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            own_mask[i] = (FLOOR_BITS'(i) == floor);
        end
        set_mask     = (open || (!up && !down)) ? (call & ~own_mask) : call;
        clr_mask     = (open && !open_d) ? own_mask : '0;
        pending_next = (pending | set_mask) & ~clr_mask;
    end

    // Priority encoders: last hit wins, giving the nearest floor on each side.
    always_comb begin
        has_above = 1'b0;
        lo_above  = '0;
        has_below = 1'b0;
        hi_below  = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            has_above = has_above | (pending[i] && (FLOOR_BITS'(i) > floor));
            lo_above  = (pending[i] && (FLOOR_BITS'(i) > floor)) ? FLOOR_BITS'(i) : lo_above;
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            has_below = has_below | (pending[i] && (FLOOR_BITS'(i) < floor));
            hi_below  = (pending[i] && (FLOOR_BITS'(i) < floor)) ? FLOOR_BITS'(i) : hi_below;
        end
        dist_up = lo_above - floor;
        dist_dn = floor - hi_below;
    end

`ifdef HOME_RETURN_EN
    localparam int CW = $clog2(IDLE_TIMEOUT) + 1;
    logic [CW-1:0] idle_cnt;
    logic          count_en;

    // Count only truly idle cycles away from floor 0; any activity restarts the wait.
    always_comb begin
        count_en  = (state == IDLE) && !busy && closed && (req != '0) && (call == '0);
        home_fire = count_en && (idle_cnt == CW'(IDLE_TIMEOUT - 1));
    end

    // Idle counter for the home return.
    always_ff @(posedge clk) begin
        if (reset || !count_en || home_fire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign home_fire = (IDLE_TIMEOUT < 0);
`endif

    // Request latch, LOOK state machine and registered target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req      <= '0;
            pending  <= '0;
            busy     <= 1'b0;
            sweep_up <= 1'b1;
            open_d   <= 1'b0;
        end else begin
            open_d  <= open;
            pending <= pending_next;
            busy    <= |pending_next;
            if (up) begin
                if (has_above && (lo_above < req)) req <= lo_above;
            end else if (down) begin
                if (has_below && (hi_below > req)) req <= hi_below;
            end else if (closed) begin
                case (state)
                    IDLE: begin
                        if (has_above && (!has_below || (dist_up <= dist_dn))) begin
                            state    <= SERVE_UP;
                            sweep_up <= 1'b1;
                            req      <= lo_above;
                        end else if (has_below) begin
                            state    <= SERVE_DOWN;
                            sweep_up <= 1'b0;
                            req      <= hi_below;
                        end else if (home_fire) begin
                            req <= '0;
                        end
                    end
                    SERVE_UP: begin
                        if (has_above) begin
                            req <= lo_above;
                        end else if (has_below) begin
                            state    <= SERVE_DOWN;
                            sweep_up <= 1'b0;
                            req      <= hi_below;
                        end else if (pending == '0) begin
                            state <= IDLE;
                        end
                    end
                    SERVE_DOWN: begin
                        if (has_below) begin
                            req <= hi_below;
                        end else if (has_above) begin
                            state    <= SERVE_UP;
                            sweep_up <= 1'b1;
                            req      <= lo_above;
                        end else if (pending == '0) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_request_resolver.sv
// Directed self-checking bench for request_resolver; ctrl_unit behaviour is driven by hand.
module tb_request_resolver;
    localparam int NF = 8;
    localparam int FB = 3;
    localparam int IDLE_TIMEOUT = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] call;
    logic [FB-1:0] floor;
    logic          up;
    logic          down;
    logic          open;
    logic [FB-1:0] req;
    logic [NF-1:0] pending;
    logic          busy;
    logic          sweep_up;

    int checks = 0;
    int errors = 0;

    request_resolver #(
        .NUM_FLOORS  (NF),
        .FLOOR_BITS  (FB),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .call    (call),
        .floor   (floor),
        .up      (up),
        .down    (down),
        .open    (open),
        .req     (req),
        .pending (pending),
        .busy    (busy),
        .sweep_up(sweep_up)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [FB-1:0] f);
        reset = 1'b1; call = '0; floor = f; up = 1'b0; down = 1'b0; open = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int changed;
        int fired_at;

        // Reset state and basic call -> pending -> req -> served clear.
        do_reset(3'd0);
        check_eq("rst_req", 32'(req), 32'd0);
        check_eq("rst_pending", 32'(pending), 32'h00);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sweep", 32'(sweep_up), 32'd1);
        call = 8'h20; step(); call = '0;
        check_eq("t1_pending", 32'(pending), 32'h20);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_req_early", 32'(req), 32'd0);
        step();
        check_eq("t1_req", 32'(req), 32'd5);
        up = 1'b1; floor = 3'd5; step();
        up = 1'b0; open = 1'b1; step();
        check_eq("t1_clr_pending", 32'(pending), 32'h00);
        check_eq("t1_clr_busy", 32'(busy), 32'd0);
        open = 1'b0; step();
        check_eq("t1_req_hold", 32'(req), 32'd5);

        // Upward intercept; calls behind the car are latched but do not steer.
        do_reset(3'd1);
        call = 8'h40; step(); call = '0; step();
        check_eq("t2_req6", 32'(req), 32'd6);
        up = 1'b1; call = 8'h08; step(); call = '0;
        check_eq("t2_pending", 32'(pending), 32'h48);
        check_eq("t2_req_hold", 32'(req), 32'd6);
        step();
        check_eq("t2_intercept", 32'(req), 32'd3);
        call = 8'h01; step(); call = '0; step();
        check_eq("t2_behind_req", 32'(req), 32'd3);
        check_eq("t2_behind_pend", 32'(pending), 32'h49);
        up = 1'b0;

        // Downward intercept mirror.
        do_reset(3'd6);
        call = 8'h02; step(); call = '0; step();
        check_eq("t3_req1", 32'(req), 32'd1);
        check_eq("t3_sweep", 32'(sweep_up), 32'd0);
        down = 1'b1; floor = 3'd5; call = 8'h08; step(); call = '0; step();
        check_eq("t3_intercept", 32'(req), 32'd3);
        call = 8'h80; step(); call = '0; step();
        check_eq("t3_behind_req", 32'(req), 32'd3);
        check_eq("t3_behind_pend", 32'(pending), 32'h8A);
        down = 1'b0;

        // LOOK: equal-distance tie goes up, then reversal after serving the top.
        do_reset(3'd4);
        call = 8'h44; step(); call = '0;
        check_eq("t4_pending", 32'(pending), 32'h44);
        step();
        check_eq("t4_req_tie", 32'(req), 32'd6);
        check_eq("t4_sweep_up", 32'(sweep_up), 32'd1);
        up = 1'b1; floor = 3'd5; step();
        floor = 3'd6; step();
        up = 1'b0; open = 1'b1; step();
        check_eq("t4_served", 32'(pending), 32'h04);
        open = 1'b0; step();
        check_eq("t4_rev_req", 32'(req), 32'd2);
        check_eq("t4_rev_sweep", 32'(sweep_up), 32'd0);

        // Own-floor calls while stopped; other-floor set survives a served clear.
        do_reset(3'd3);
        call = 8'h08; step(); call = '0;
        check_eq("t5_own_idle", 32'(pending), 32'h00);
        check_eq("t5_own_busy", 32'(busy), 32'd0);
        step();
        check_eq("t5_own_req", 32'(req), 32'd0);
        open = 1'b1; call = 8'h08; step(); call = '0;
        check_eq("t5_own_open", 32'(pending), 32'h00);
        open = 1'b0; step();
        open = 1'b1; call = 8'h28; step(); call = '0;
        check_eq("t5_set_clr", 32'(pending), 32'h20);
        check_eq("t5_set_busy", 32'(busy), 32'd1);
        open = 1'b0;

        // Reset mid-run with everything pending.
        do_reset(3'd6);
        call = 8'h80; step(); call = '0; step();
        down = 1'b1; call = 8'hFF; step(); call = '0; step();
        check_eq("t6_pend_full", 32'(pending), 32'hFF);
        check_eq("t6_req7", 32'(req), 32'd7);
        reset = 1'b1; down = 1'b0; step(); reset = 1'b0;
        check_eq("t6_rst_req", 32'(req), 32'd0);
        check_eq("t6_rst_pend", 32'(pending), 32'h00);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_sweep", 32'(sweep_up), 32'd1);

        // Idle at floor 4: home return only when the option is built.
        do_reset(3'd0);
        call = 8'h10; step(); call = '0; step();
        up = 1'b1; floor = 3'd4; step();
        up = 1'b0; open = 1'b1; step();
        open = 1'b0; step();
        check_eq("t7_idle_req", 32'(req), 32'd4);
        check_eq("t7_idle_busy", 32'(busy), 32'd0);
`ifdef HOME_RETURN_EN
        fired_at = -1;
        for (int n = 1; n <= IDLE_TIMEOUT + 4; n++) begin
            step();
            if (fired_at < 0 && req == 3'd0) fired_at = n;
        end
        check_eq("t7_home_fired", 32'(fired_at >= IDLE_TIMEOUT - 1 && fired_at <= IDLE_TIMEOUT + 1), 32'd1);
        check_eq("t7_home_req", 32'(req), 32'd0);
        check_eq("t7_home_pend", 32'(pending), 32'h00);
`else
        changed = 0;
        fired_at = 0;
        for (int n = 0; n < 2 * IDLE_TIMEOUT; n++) begin
            step();
            if (req != 3'd4) changed++;
        end
        check_eq("t7_hold_changes", 32'(changed), 32'(fired_at));
        check_eq("t7_hold_req", 32'(req), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
